eth_phy_init_seq: RTL

//  Upstream command sequencer for the MDIO management frame engine. On start it issues a fixed table of
//  PHY register writes over a valid/ready command interface. It then polls a PHY status register by MDIO

---
 rtl/eth_phy_init_seq.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_phy_init_seq.sv
// eth_phy_init_seq
//   Command sequencer in front of an MDIO frame engine. On start it writes a
//   fixed table of seven PHY registers over a valid/ready command port. It then
//   polls a status register by MDIO read until the link bit is seen, or until
//   the poll budget is used up.
//
//   Optional feature (macro ETH_PHY_SRST_WAIT_EN): after a write to register 0
//   with bit 15 set, register 0 is read back, with a gap between reads, until
//   bit 15 clears. The sequence then moves on to the next table entry. These
//   reads count against POLL_MAX.
//
// Ports
//   clk, areset_n           clock, asynchronous active-low reset
//   start                   begin sequence (accepted only in IDLE/DONE/FAIL)
//   cmd_valid/cmd_ready     command handshake toward the MDIO master
//   cmd_write, cmd_phy_ad,
//   cmd_reg_ad, cmd_wdata   command fields
//   rsp_valid, rsp_rdata    frame-complete pulse and read data
//   busy, done, link_up,
//   error                   status levels
module eth_phy_init_seq #(
  parameter logic [4:0] PHY_ADDR   = 5'h10,
  parameter int         GAP_CYCLES = 16,
  parameter logic [4:0] POLL_REG   = 5'd1,
  parameter int         LINK_BIT   = 2,
  parameter int         POLL_MAX   = 1000
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        start,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [4:0]  cmd_phy_ad,
  output logic [4:0]  cmd_reg_ad,
  output logic [15:0] cmd_wdata,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        done,
  output logic        link_up,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE, S_ISSUE, S_WAIT_RSP, S_GAP, S_POLL_ISSUE,
    S_POLL_WAIT, S_POLL_GAP, S_DONE, S_FAIL
  } state_t;

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] poll_q, poll_d;
  logic [15:0] gap_q, gap_d;
  logic        done_q, done_d;
  logic        link_q, link_d;
  logic        err_q, err_d;
  // Set while register-0 soft-reset readback reads are outstanding.
  logic        srst_q, srst_d;

  logic [15:0] poll_inc;
  logic [20:0] tbl_ent;
  logic        unused_rdata;

  // Init table: {reg address, write data}
  function automatic logic [20:0] tbl(input logic [2:0] i);
    case (i)
      3'd0:    return {5'd16, 16'h0060};
      3'd1:    return {5'd0,  16'h8140};
      3'd2:    return {5'd20, 16'h0070};
      3'd3:    return {5'd0,  16'h8140};
      3'd4:    return {5'd29, 16'h0012};
      3'd5:    return {5'd30, 16'h8240};
      default: return {5'd0,  16'h8140};
    endcase
  endfunction

  assign tbl_ent      = tbl(idx_q);
  assign poll_inc     = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
  assign unused_rdata = ^rsp_rdata;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      poll_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      link_q  <= 1'b0;
      err_q   <= 1'b0;
      srst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      link_q  <= link_d;
      err_q   <= err_d;
      srst_q  <= srst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    poll_d     = poll_q;
    gap_d      = gap_q;
    done_d     = done_q;
    link_d     = link_q;
    err_d      = err_q;
    srst_d     = srst_q;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_phy_ad = 5'd0;
    cmd_reg_ad = 5'd0;
    cmd_wdata  = 16'd0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d = S_ISSUE;
          done_d  = 1'b0;
          link_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          poll_d  = '0;
          srst_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_phy_ad = PHY_ADDR;
        cmd_reg_ad = tbl_ent[20:16];
        cmd_wdata  = tbl_ent[15:0];
        if (cmd_ready) state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
`ifdef ETH_PHY_SRST_WAIT_EN
          srst_d  = (tbl_ent[20:16] == 5'd0) && tbl_ent[15];
`endif
        end
      end
      S_GAP: begin
        if (gap_q != 16'd0) begin
          gap_d = gap_q - 16'd1;
        end else if (srst_q || idx_q == 3'd6) begin
          state_d = S_POLL_ISSUE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_POLL_ISSUE: begin
        cmd_valid  = 1'b1;
        cmd_phy_ad = PHY_ADDR;
        cmd_reg_ad = srst_q ? 5'd0 : POLL_REG;
        if (cmd_ready) state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (rsp_valid) begin
          poll_d = poll_inc;
          if (srst_q && !rsp_rdata[15]) begin
            // Soft reset finished: gap, then resume the table.
            srst_d  = 1'b0;
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else if (!srst_q && rsp_rdata[LINK_BIT]) begin
            state_d = S_DONE;
            link_d  = 1'b1;
            done_d  = 1'b1;
          end else if (poll_inc == POLL_LIM) begin
            state_d = S_FAIL;
            err_d   = 1'b1;
          end else begin
            state_d = S_POLL_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      S_POLL_GAP: begin
        if (gap_q != 16'd0) gap_d = gap_q - 16'd1;
        else                state_d = S_POLL_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign done    = done_q;
  assign link_up = link_q;
  assign error   = err_q;

endmodule
